dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: LINE_W, 256, line data width.
REQ-003 Parameter: TIMEOUT, 1023, max cycles granted without mem_ack_i (range 1..1023).
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 m0_enable_i / m1_enable_i  in  1  request (m0 = icache, m1 = dcache); held high until ack.
REQ-007 m0_write_i / m1_write_i  in  1  1 = line write, 0 = line read.
REQ-008 m0_addr_i / m1_addr_i  in  ADDR_W  line address, bits [4:0] zero.
REQ-009 m0_data_i / m1_data_i  in  LINE_W  write line.
REQ-010 m0_data_o / m1_data_o  out  LINE_W  read line, equal to mem_data_i.
REQ-011 m0_ack_o / m1_ack_o  out  1  completion pulse to the granted requester only.
REQ-012 mem_enable_o  out  1  request to data memory.
REQ-013 mem_write_o, mem_addr_o, mem_data_o  out  1/ADDR_W/LINE_W  muxed from the granted requester.
REQ-014 mem_data_i  in  LINE_W; mem_ack_i  in  1  single-cycle completion from memory.
REQ-015 timeout_o  out  1  sticky error flag.

Function
REQ-016 States: IDLE, GNT0, GNT1; state and grant are registered.
REQ-017 IDLE: m0 request only -> GNT0; m1 request only -> GNT1; no request -> IDLE.
REQ-018 IDLE with both requesting -> grant the requester not granted last (round-robin, pointer last_gnt).
REQ-019 last_gnt updates on entry to GNTx.
REQ-020 Latency: request sampled in IDLE at edge N -> mem_enable_o high from cycle N+1.
REQ-021 mem_enable_o = 1 exactly in GNT0/GNT1, independent of the granted requester's enable level.
REQ-022 In GNTx, mem_write_o, mem_addr_o and mem_data_o follow mx inputs combinationally.
REQ-023 In IDLE, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
REQ-024 mx_ack_o = mem_ack_i AND (state == GNTx), combinational; never asserted to the non-granted side.
REQ-025 mem_ack_i in GNTx -> IDLE; this forces at least one cycle with mem_enable_o low between transactions.
REQ-026 A requester that keeps enable high after ack (dcache writeback followed by refill) is a new request and re-arbitrates by round-robin.
REQ-027 mem_ack_i in IDLE is ignored: no mx_ack_o, no state change.
REQ-028 Watchdog counter clears on entry to GNTx and increments each granted cycle without ack.
REQ-029 Count reaching TIMEOUT -> set timeout_o, return to IDLE, no ack issued.
REQ-030 timeout_o stays set until reset.
REQ-031 Requester enable dropped mid-grant (protocol violation): grant is held until ack or timeout.

Reset
REQ-032 rst_i low asynchronously forces state = IDLE, last_gnt = 1 (m0 wins first tie), watchdog = 0, timeout_o = 0.
REQ-033 During reset all outputs are 0.
REQ-034 Reset mid-transaction abandons the transaction; a late mem_ack_i after release is ignored per REQ-027.

Structure
REQ-035 Shared package dmem_arb_pkg holds the state encoding, ADDR_W/LINE_W defaults and the watchdog width (10 bits).
REQ-036 Single module; no sub-module; the output mux and ack gating are combinational, all else registered.

Verification
REQ-037 Single read: m0 read addr 0x00000400, memory acks 10 cycles after enable -> mem_enable_o high from the cycle after request, m0_ack_o one pulse, m0_data_o = mem_data_i, m1_ack_o = 0.
REQ-038 Tie: m0 and m1 request the same cycle after reset -> m0 granted first; m1 granted after the 1-cycle IDLE gap; the next tie goes to m0 again.
REQ-039 Dcache writeback + refill: m1 write 0x00001000, then enable held high for a read of 0x00002000 while m0 waits -> sequence m1 write, m0, m1 read.
REQ-040 Timeout with TIMEOUT = 16 and no ack -> return to IDLE after 16 granted cycles, timeout_o = 1 and sticky, no ack pulses.
REQ-041 Reset asserted in GNT1 mid-transaction -> outputs 0 immediately; a stray mem_ack_i after release produces no mx_ack_o.
REQ-042 Random dual traffic for 10k cycles -> no ack to a non-granted requester, mem_enable_o low at least 1 cycle between grants, no starvation beyond one transaction.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, default
// bus widths and the watchdog counter width.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;   // default line address width
  localparam int unsigned DEF_LINE_W = 256;  // default line data width
  localparam int unsigned WDOG_W     = 10;   // watchdog width, covers TIMEOUT up to 1023

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter (m0 = icache, m1 = dcache) in front of a single data
// memory port. Round-robin between simultaneous requests, one transaction at a
// time, mandatory idle cycle between transactions, and a watchdog that abandons
// a grant the memory never acknowledges and raises a sticky error flag.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   mX_enable_i             request, held high until mX_ack_o
//   mX_write_i              1 = line write, 0 = line read
//   mX_addr_i / mX_data_i   line address / write line of requester X
//   mX_data_o / mX_ack_o    read line / completion pulse to requester X
//   mem_enable_o            high exactly while a requester is granted
//   mem_write_o/addr_o/data_o  request fields of the granted requester
//   mem_data_i / mem_ack_i  read line / single-cycle completion from memory
//   timeout_o               sticky watchdog error flag
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic [LINE_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              timeout_o
);

  // Last granted-cycle count before the watchdog fires: a grant lasts at most
  // TIMEOUT cycles without an acknowledge.
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_last_gnt;   // 0 = m0 granted last, 1 = m1 granted last
  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout;

  state_t            w_state_nxt;
  logic              w_timeout_set;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_enter_gnt;

  assign w_gnt0      = (r_state == ST_GNT0);
  assign w_gnt1      = (r_state == ST_GNT1);
  assign w_enter_gnt = (r_state == ST_IDLE) && (w_state_nxt != ST_IDLE);

  // Next-state logic. The requester's enable is deliberately not looked at once
  // granted: a grant only ends on acknowledge or watchdog expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_enable_i && m1_enable_i) begin
          // Tie: the side that was not granted last wins.
          w_state_nxt = r_last_gnt ? ST_GNT0 : ST_GNT1;
        end else if (m0_enable_i) begin
          w_state_nxt = ST_GNT0;
        end else if (m1_enable_i) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (mem_ack_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wdog == WDOG_LIMIT) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_set = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;          // makes m0 win the first tie
      r_wdog     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      if (w_enter_gnt) begin
        r_last_gnt <= (w_state_nxt == ST_GNT1);
        r_wdog     <= '0;
      end else if ((r_state != ST_IDLE) && !mem_ack_i) begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Memory-side request mux; all zero while idle (and therefore in reset).
  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    if (w_gnt0) begin
      mem_write_o = m0_write_i;
      mem_addr_o  = m0_addr_i;
      mem_data_o  = m0_data_i;
    end else if (w_gnt1) begin
      mem_write_o = m1_write_i;
      mem_addr_o  = m1_addr_i;
      mem_data_o  = m1_data_i;
    end
  end

  assign mem_enable_o = w_gnt0 | w_gnt1;

  // Acks reach only the granted side; an ack while idle is dropped here. The
  // read line is steered the same way so a requester never sees another's data
  // and all outputs are zero while the state register is held in reset.
  assign m0_ack_o  = mem_ack_i & w_gnt0;
  assign m1_ack_o  = mem_ack_i & w_gnt1;
  assign m0_data_o = w_gnt0 ? mem_data_i : '0;
  assign m1_data_o = w_gnt1 ? mem_data_i : '0;

  assign timeout_o = r_timeout;

endmodule : dmem_arbiter
